// File: rtl/vend_pkg.sv
// Shared definitions for the vending credit controller.
//   vend_state_t : controller state encoding
//   HALF_VAL     : credit value of a half-unit coin (in half-units)
//   ONE_VAL      : credit value of a one-unit coin (in half-units)
//   credit_w_ok  : true when a credit register of the given width can hold price+2
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StVend,
        StChange,
        StRefund
    } vend_state_t;

    localparam int unsigned HALF_VAL = 1;
    localparam int unsigned ONE_VAL  = 2;

    // Worst-case credit is price-1 plus a simultaneous half+one (3), i.e. price+2.
    function automatic bit credit_w_ok(input int unsigned price, input int unsigned width);
        if (width == 0 || width > 31) begin
            return 1'b0;
        end
        return (64'd1 << width) > (64'(price) + 64'd2);
    endfunction

endpackage

// File: rtl/vend_payout_ctr.sv
// Loadable down-counter that paces change and refund pulses.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low
//   load_i   : load value_i into the counter (takes priority over counting)
//   value_i  : number of half-unit pulses to pay
//   active_o : counter non-zero; one change pulse is paid this cycle
//   done_o   : this is the last pulse of the current payout
//   count_o  : remaining half-units still owed, including this cycle's pulse
module vend_payout_ctr
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [CREDIT_W-1:0] value_i,
    output logic                active_o,
    output logic                done_o,
    output logic [CREDIT_W-1:0] count_o
);

    logic [CREDIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active_o = (cnt_q != '0);
    assign done_o   = (cnt_q == CREDIT_W'(1));
    assign count_o  = cnt_q;

endmodule

// File: rtl/vend_credit_fsm.sv
// Moore vending controller: accumulates half/one-unit coins, strobes a vend once
// credit reaches PRICE_HALVES, then pays back excess as serial half-unit pulses.
// Optional feature macro: VEND_CANCEL_EN adds cancel_i and the refund path.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low
//   half_i     : half-unit coin pulse
//   one_i      : one-unit coin pulse (two halves)
//   cancel_i   : refund request, honoured only while collecting (VEND_CANCEL_EN)
//   out_o      : vend strobe, one cycle per sale
//   cout_o     : change pulse, one half-unit per high cycle
//   coin_rej_o : registered; a coin arrived while busy and was not credited
//   busy_o     : vending, paying change or refunding
//   credit_o   : current credit in half-units
module vend_credit_fsm
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_HALVES = 5,
    parameter int unsigned CREDIT_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                half_i,
    input  logic                one_i,
`ifdef VEND_CANCEL_EN
    input  logic                cancel_i,
`endif
    output logic                out_o,
    output logic                cout_o,
    output logic                coin_rej_o,
    output logic                busy_o,
    output logic [CREDIT_W-1:0] credit_o
);

    if (PRICE_HALVES < 1) begin : g_bad_price
        $fatal(1, "vend_credit_fsm: PRICE_HALVES must be at least 1");
    end
    if (!credit_w_ok(PRICE_HALVES, CREDIT_W)) begin : g_bad_width
        $fatal(1, "vend_credit_fsm: CREDIT_W too small for PRICE_HALVES+2");
    end

    localparam logic [CREDIT_W-1:0] Price = CREDIT_W'(PRICE_HALVES);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_rej_q, coin_rej_d;

    logic [1:0]          coin_sum;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] remainder;

    logic                ctr_load;
    logic [CREDIT_W-1:0] ctr_value;
    logic                ctr_active;
    logic                ctr_done;
    logic [CREDIT_W-1:0] ctr_count;

    // Both coins in one cycle are credited together; no priority drop.
    assign coin_sum   = (half_i ? 2'(HALF_VAL) : 2'd0) + (one_i ? 2'(ONE_VAL) : 2'd0);
    assign credit_sum = credit_q + CREDIT_W'(coin_sum);
    assign remainder  = credit_q - Price;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, including credit bookkeeping and payout loading.
    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        ctr_load  = 1'b0;
        ctr_value = '0;
        unique case (state_q)
            StIdle, StCollect: begin
                credit_d = credit_sum;
                if (credit_sum >= Price) begin
                    state_d = StVend;
                end else if (credit_sum != '0) begin
                    state_d = StCollect;
`ifdef VEND_CANCEL_EN
                    // Coin is credited first, then the whole balance is refunded.
                    if (state_q == StCollect && cancel_i) begin
                        state_d   = StRefund;
                        ctr_load  = 1'b1;
                        ctr_value = credit_sum;
                        credit_d  = '0;
                    end
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StVend: begin
                // Excess moves into the payout counter; credit_o follows it from there.
                credit_d = '0;
                if (remainder != '0) begin
                    state_d   = StChange;
                    ctr_load  = 1'b1;
                    ctr_value = remainder;
                end else begin
                    state_d = StIdle;
                end
            end
            StChange, StRefund: begin
                if (ctr_done || !ctr_active) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs.
    always_comb begin
        out_o  = 1'b0;
        busy_o = 1'b0;
        unique case (state_q)
            StVend: begin
                out_o  = 1'b1;
                busy_o = 1'b1;
            end
            StChange, StRefund: begin
                busy_o = 1'b1;
            end
            default: begin
                out_o  = 1'b0;
                busy_o = 1'b0;
            end
        endcase
    end

    assign coin_rej_d = busy_o && (half_i || one_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q   <= '0;
            coin_rej_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    vend_payout_ctr #(
        .CREDIT_W(CREDIT_W)
    ) u_payout (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ctr_load),
        .value_i (ctr_value),
        .active_o(ctr_active),
        .done_o  (ctr_done),
        .count_o (ctr_count)
    );

    // Counter is non-zero only in CHANGE/REFUND, so cout_o is still a state decode.
    assign cout_o     = ctr_active;
    assign coin_rej_o = coin_rej_q;
    assign credit_o   = ctr_active ? ctr_count : credit_q;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Bench for vend_credit_fsm: two instances (price 5 / width 4 and price 1 / width 2)
// share one stimulus stream and are compared every cycle against a credit/payout model.
module tb_vend_credit_fsm;

`ifdef VEND_CANCEL_EN
    localparam bit CancelEn = 1'b1;
`else
    localparam bit CancelEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       half = 1'b0;
    logic       one = 1'b0;
    logic       cancel = 1'b0;

    logic       d0_out, d0_cout, d0_rej, d0_busy;
    logic [3:0] d0_credit;
    logic       d1_out, d1_cout, d1_rej, d1_busy;
    logic [1:0] d1_credit;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vend_credit_fsm #(
        .PRICE_HALVES(5),
        .CREDIT_W    (4)
    ) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .half_i    (half),
        .one_i     (one),
`ifdef VEND_CANCEL_EN
        .cancel_i  (cancel),
`endif
        .out_o     (d0_out),
        .cout_o    (d0_cout),
        .coin_rej_o(d0_rej),
        .busy_o    (d0_busy),
        .credit_o  (d0_credit)
    );

    vend_credit_fsm #(
        .PRICE_HALVES(1),
        .CREDIT_W    (2)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .half_i    (half),
        .one_i     (one),
`ifdef VEND_CANCEL_EN
        .cancel_i  (cancel),
`endif
        .out_o     (d1_out),
        .cout_o    (d1_cout),
        .coin_rej_o(d1_rej),
        .busy_o    (d1_busy),
        .credit_o  (d1_credit)
    );

    // Model: credit held while collecting, a pending-vend flag, change still owed.
    int price [2] = '{5, 1};
    int m_credit [2];
    int m_pay [2];
    bit m_vend [2];
    bit m_rej [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_credit[i] = 0; m_pay[i] = 0; m_vend[i] = 0; m_rej[i] = 0;
        end
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int i = 0; i < 2; i++) begin
                    m_credit[i] = 0; m_pay[i] = 0; m_vend[i] = 0; m_rej[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    int s;
                    int c;
                    bit was_busy;
                    was_busy = m_vend[i] || (m_pay[i] > 0);
                    m_rej[i] = was_busy && (half || one);
                    s = int'(half) + 2 * int'(one);
                    if (m_vend[i]) begin
                        m_pay[i] = m_credit[i] - price[i];
                        m_credit[i] = 0;
                        m_vend[i] = 0;
                    end else if (m_pay[i] > 0) begin
                        m_pay[i] = m_pay[i] - 1;
                    end else begin
                        c = m_credit[i] + s;
                        if (c >= price[i]) begin
                            m_credit[i] = c;
                            m_vend[i] = 1;
                        end else if (CancelEn && cancel && m_credit[i] > 0) begin
                            m_pay[i] = c;
                            m_credit[i] = 0;
                        end else begin
                            m_credit[i] = c;
                        end
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int e_credit;
                bit e_busy;
                int a_out, a_cout, a_rej, a_busy, a_credit;
                e_busy = m_vend[i] || (m_pay[i] > 0);
                e_credit = (m_pay[i] > 0) ? m_pay[i] : m_credit[i];
                if (i == 0) begin
                    a_out = int'(d0_out); a_cout = int'(d0_cout); a_rej = int'(d0_rej);
                    a_busy = int'(d0_busy); a_credit = int'(d0_credit);
                end else begin
                    a_out = int'(d1_out); a_cout = int'(d1_cout); a_rej = int'(d1_rej);
                    a_busy = int'(d1_busy); a_credit = int'(d1_credit);
                end
                chk($sformatf("model_out[%0d]", i), a_out, int'(m_vend[i]));
                chk($sformatf("model_cout[%0d]", i), a_cout, int'(m_pay[i] > 0));
                chk($sformatf("model_rej[%0d]", i), a_rej, int'(m_rej[i]));
                chk($sformatf("model_busy[%0d]", i), a_busy, int'(e_busy));
                chk($sformatf("model_credit[%0d]", i), a_credit, e_credit);
            end
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic step(input bit h, input bit o, input bit c);
        half = h; one = o; cancel = c;
        @(posedge clk);
        #1;
        half = 1'b0; one = 1'b0; cancel = 1'b0;
    endtask

    task automatic d0_expect(input string name, input int o, input int co, input int b,
                             input int cr);
        chk({name, "_out"}, int'(d0_out), o);
        chk({name, "_cout"}, int'(d0_cout), co);
        chk({name, "_busy"}, int'(d0_busy), b);
        chk({name, "_credit"}, int'(d0_credit), cr);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        d0_expect("reset", 0, 0, 0, 0);
        chk("reset_rej", int'(d0_rej), 0);
        chk("reset_d1_credit", int'(d1_credit), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // half, half, one, one -> 1, 2, 4, 6; vend then one change pulse.
        step(1, 0, 0); d0_expect("a1", 0, 0, 0, 1);
        step(1, 0, 0); d0_expect("a2", 0, 0, 0, 2);
        step(0, 1, 0); d0_expect("a3", 0, 0, 0, 4);
        step(0, 1, 0); d0_expect("a4", 1, 0, 1, 6);
        step(0, 0, 0); d0_expect("a5", 0, 1, 1, 1);
        step(0, 0, 0); d0_expect("a6", 0, 0, 0, 0);

        // Simultaneous half+one, then one: exact price, idle right after the vend.
        step(1, 1, 0); d0_expect("b1", 0, 0, 0, 3);
        step(0, 1, 0); d0_expect("b2", 1, 0, 1, 5);
        step(0, 0, 0); d0_expect("b3", 0, 0, 0, 0);
        step(1, 0, 0); d0_expect("b4", 0, 0, 0, 1);
        chk("b4_rej", int'(d0_rej), 0);

        // Coins during out and during cout are rejected and not credited.
        step(1, 1, 0); d0_expect("c1", 0, 0, 0, 4);
        step(1, 0, 0); d0_expect("c2", 1, 0, 1, 5);
        step(0, 1, 0); d0_expect("c3", 0, 0, 0, 0);
        chk("c3_rej", int'(d0_rej), 1);
        step(0, 1, 0); d0_expect("c4", 0, 0, 0, 2);
        chk("c4_rej", int'(d0_rej), 0);
        step(0, 1, 0);
        step(0, 1, 0); d0_expect("c6", 1, 0, 1, 6);
        step(0, 0, 0); d0_expect("c7", 0, 1, 1, 1);
        step(1, 0, 0); d0_expect("c8", 0, 0, 0, 0);
        chk("c8_rej", int'(d0_rej), 1);

        // Reset mid-change: everything clears at once and the change is forfeited.
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0); d0_expect("d1", 1, 0, 1, 7);
        step(0, 0, 0); d0_expect("d2", 0, 1, 1, 2);
        #2;
        reset = 1'b0;
        #1;
        d0_expect("d3", 0, 0, 0, 0);
        chk("d3_rej", int'(d0_rej), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        d0_expect("d4", 0, 0, 0, 0);

        // Cancel after credit 3: refund of three pulses with no vend.
        step(1, 1, 0); d0_expect("e1", 0, 0, 0, 3);
        if (CancelEn) begin
            step(0, 0, 1); d0_expect("e2", 0, 1, 1, 3);
            step(0, 0, 0); d0_expect("e3", 0, 1, 1, 2);
            step(0, 0, 0); d0_expect("e4", 0, 1, 1, 1);
            step(0, 0, 0); d0_expect("e5", 0, 0, 0, 0);
        end else begin
            step(0, 0, 1);
            repeat (4) step(0, 0, 0);
            d0_expect("e_hold", 0, 0, 0, 3);
        end
        reset_pulse();

        // Price 1, width 2: a one-unit coin vends then pays one half-unit.
        step(0, 1, 0);
        chk("f1_out", int'(d1_out), 1);
        chk("f1_credit", int'(d1_credit), 2);
        step(0, 0, 0);
        chk("f2_out", int'(d1_out), 0);
        chk("f2_cout", int'(d1_cout), 1);
        chk("f2_credit", int'(d1_credit), 1);
        step(0, 0, 0);
        chk("f3_cout", int'(d1_cout), 0);
        chk("f3_busy", int'(d1_busy), 0);
        chk("f3_credit", int'(d1_credit), 0);

        // Random traffic, with occasional short asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            bit h, o, c;
            h = ($urandom_range(0, 9) < 3);
            o = ($urandom_range(0, 9) < 3);
            c = ($urandom_range(0, 9) < 1);
            step(h, o, c);
            if ($urandom_range(0, 199) == 0) begin
                #1;
                reset = 1'b0;
                #2;
                reset = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
